// File: rtl/branch_predict_unit.sv
// branch_predict_unit
//   Resolves the six MIPS conditional branches (BEQ, BNE, BLEZ, BGTZ, BLTZ,
//   BGEZ) in EX. It also keeps a PC-indexed table of 2-bit saturating
//   counters that gives fetch a taken/not-taken prediction. Outputs are a
//   registered direction, a one-cycle mispredict flush pulse and saturating
//   statistics counters.
//
// Ports
//   i_clk              system clock, rising edge
//   i_rst_n            asynchronous active-low reset
//   i_lookup_pc        fetch-stage PC used for the prediction lookup
//   o_predict_taken    combinational prediction, MSB of the indexed counter
//   i_res_valid        a branch resolves in EX this cycle
//   i_res_pc           PC of the resolving branch
//   i_res_type         1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, else none
//   i_res_pred         prediction that travelled with the branch from fetch
//   i_rs_data          rs operand
//   i_rt_data          rt operand
//   i_stall            EX frozen; the resolve is ignored
//   o_branch_taken     registered resolved direction
//   o_mispredict       registered one-cycle flush pulse
//   o_stat_branches    saturating count of accepted branches
//   o_stat_mispredicts saturating count of mispredicted branches

module branch_predict_unit #(
   parameter int WIDTH      = 32,
   parameter int PHT_DEPTH  = 64,
   parameter int INIT_STATE = 1,
   parameter int STAT_W     = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [WIDTH-1:0]  i_lookup_pc,
   output logic              o_predict_taken,
   input  logic              i_res_valid,
   input  logic [WIDTH-1:0]  i_res_pc,
   input  logic [2:0]        i_res_type,
   input  logic              i_res_pred,
   input  logic [WIDTH-1:0]  i_rs_data,
   input  logic [WIDTH-1:0]  i_rt_data,
   input  logic              i_stall,
   output logic              o_branch_taken,
   output logic              o_mispredict,
   output logic [STAT_W-1:0] o_stat_branches,
   output logic [STAT_W-1:0] o_stat_mispredicts
);

   localparam int         IDX     = $clog2(PHT_DEPTH);
   localparam logic [1:0] INIT_CT = INIT_STATE[1:0];

   localparam logic [2:0] T_BEQ  = 3'd1;
   localparam logic [2:0] T_BNE  = 3'd2;
   localparam logic [2:0] T_BLEZ = 3'd3;
   localparam logic [2:0] T_BGTZ = 3'd4;
   localparam logic [2:0] T_BLTZ = 3'd5;
   localparam logic [2:0] T_BGEZ = 3'd6;

   logic [1:0]        r_pht [PHT_DEPTH];
   logic              r_branch_taken;
   logic              r_mispredict;
   logic [STAT_W-1:0] r_stat_branches;
   logic [STAT_W-1:0] r_stat_mispredicts;

   logic [IDX-1:0]    w_lookup_idx;
   logic [IDX-1:0]    w_res_idx;
   logic              w_rs_neg;
   logic              w_rs_zero;
   logic              w_rs_eq_rt;
   logic              w_cond;
   logic              w_type_ok;
   logic              w_accept;
   logic              w_miss;
   logic [1:0]        w_res_ctr;

   // Word-aligned index; PC bits [1:0] and bits above IDX+1 are deliberately
   // ignored, so distant branches may alias onto the same counter.
   assign w_lookup_idx = i_lookup_pc[IDX+1:2];
   assign w_res_idx    = i_res_pc[IDX+1:2];

   logic w_unused_pc_bits;
   assign w_unused_pc_bits = ^{i_lookup_pc[1:0], i_lookup_pc[WIDTH-1:IDX+2],
                               i_res_pc[1:0], i_res_pc[WIDTH-1:IDX+2]};

   // No bypass: a same-cycle update to this entry shows up one cycle later.
   assign o_predict_taken = r_pht[w_lookup_idx][1];

   assign w_rs_neg   = i_rs_data[WIDTH-1];
   assign w_rs_zero  = (i_rs_data == '0);
   assign w_rs_eq_rt = (i_rs_data == i_rt_data);

   always_comb begin
      w_cond    = 1'b0;
      w_type_ok = 1'b1;
      case (i_res_type)
         T_BEQ:   w_cond = w_rs_eq_rt;
         T_BNE:   w_cond = !w_rs_eq_rt;
         T_BLEZ:  w_cond = w_rs_neg || w_rs_zero;
         T_BGTZ:  w_cond = !w_rs_neg && !w_rs_zero;
         T_BLTZ:  w_cond = w_rs_neg;
         T_BGEZ:  w_cond = !w_rs_neg;
         default: w_type_ok = 1'b0;
      endcase
   end

   assign w_accept  = i_res_valid && !i_stall && w_type_ok;
   assign w_miss    = w_accept && (w_cond != i_res_pred);
   assign w_res_ctr = r_pht[w_res_idx];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < PHT_DEPTH; i++) begin
            r_pht[i] <= INIT_CT;
         end
      end else if (w_accept) begin
         if (w_cond && (w_res_ctr != 2'd3)) begin
            r_pht[w_res_idx] <= w_res_ctr + 2'd1;
         end else if (!w_cond && (w_res_ctr != 2'd0)) begin
            r_pht[w_res_idx] <= w_res_ctr - 2'd1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_branch_taken <= 1'b0;
         r_mispredict   <= 1'b0;
      end else begin
         r_branch_taken <= w_accept && w_cond;
         r_mispredict   <= w_miss;
      end
   end

   // Statistics stop at all-ones rather than wrapping.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stat_branches    <= '0;
         r_stat_mispredicts <= '0;
      end else if (w_accept) begin
         if (!(&r_stat_branches)) begin
            r_stat_branches <= r_stat_branches + 1'b1;
         end
         if (w_miss && !(&r_stat_mispredicts)) begin
            r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
         end
      end
   end

   assign o_branch_taken     = r_branch_taken;
   assign o_mispredict       = r_mispredict;
   assign o_stat_branches    = r_stat_branches;
   assign o_stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Testbench for branch_predict_unit. Two instances share all stimulus: one
// with default parameters, one with 4-bit statistics so saturation is reached.

module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] lookup_pc = '0;
   logic        res_valid = 1'b0;
   logic [31:0] res_pc = '0;
   logic [2:0]  res_type = '0;
   logic        res_pred = 1'b0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        stall = 1'b0;

   logic        predict_taken, branch_taken, mispredict;
   logic [15:0] stat_br, stat_mp;
   logic        predict_taken4, branch_taken4, mispredict4;
   logic [3:0]  stat_br4, stat_mp4;

   int checks = 0;
   int failures = 0;

   // reference model state
   int pht [64];
   int n_br, n_mp;

   always #5 clk = ~clk;

   branch_predict_unit u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_lookup_pc(lookup_pc),
      .o_predict_taken(predict_taken), .i_res_valid(res_valid),
      .i_res_pc(res_pc), .i_res_type(res_type), .i_res_pred(res_pred),
      .i_rs_data(rs_data), .i_rt_data(rt_data), .i_stall(stall),
      .o_branch_taken(branch_taken), .o_mispredict(mispredict),
      .o_stat_branches(stat_br), .o_stat_mispredicts(stat_mp)
   );

   branch_predict_unit #(.STAT_W(4)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_lookup_pc(lookup_pc),
      .o_predict_taken(predict_taken4), .i_res_valid(res_valid),
      .i_res_pc(res_pc), .i_res_type(res_type), .i_res_pred(res_pred),
      .i_rs_data(rs_data), .i_rt_data(rt_data), .i_stall(stall),
      .o_branch_taken(branch_taken4), .o_mispredict(mispredict4),
      .o_stat_branches(stat_br4), .o_stat_mispredicts(stat_mp4)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_cond(input logic [2:0] t, input logic [31:0] rs,
                                     input logic [31:0] rt);
      int signed a;
      a = int'(rs);
      case (t)
         3'd1:    return rs == rt;
         3'd2:    return rs != rt;
         3'd3:    return a <= 0;
         3'd4:    return a > 0;
         3'd5:    return a < 0;
         3'd6:    return a >= 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int pidx(input logic [31:0] pc);
      return int'((pc >> 2) % 64);
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) pht[i] = 1;
      n_br = 0;
      n_mp = 0;
   endtask

   task automatic check_regs(input bit exp_bt, input bit exp_mp);
      chk("branch_taken", branch_taken, exp_bt);
      chk("mispredict", mispredict, exp_mp);
      chk("mispredict_w4", mispredict4, exp_mp);
      chk("stat_branches", stat_br, sat(n_br, 65535));
      chk("stat_mispredicts", stat_mp, sat(n_mp, 65535));
      chk("stat_branches_w4", stat_br4, sat(n_br, 15));
      chk("stat_mispredicts_w4", stat_mp4, sat(n_mp, 15));
   endtask

   task automatic drive(input bit v, input logic [31:0] pc, input logic [2:0] t,
                        input bit pred, input logic [31:0] rs, input logic [31:0] rt,
                        input bit st, input logic [31:0] lpc);
      res_valid = v; res_pc = pc; res_type = t; res_pred = pred;
      rs_data = rs; rt_data = rt; stall = st; lookup_pc = lpc;
   endtask

   // Called at posedge+1 with inputs already driven; advances one cycle.
   task automatic step();
      bit acc, c, exp_bt, exp_mp;
      #1;
      chk("predict_taken", predict_taken, pht[pidx(lookup_pc)] >= 2);
      c   = model_cond(res_type, rs_data, rt_data);
      acc = res_valid && !stall && (res_type >= 3'd1) && (res_type <= 3'd6);
      exp_bt = acc && c;
      exp_mp = acc && (c != res_pred);
      @(posedge clk);
      #1;
      if (acc) begin
         if (c) pht[pidx(res_pc)] = (pht[pidx(res_pc)] == 3) ? 3 : pht[pidx(res_pc)] + 1;
         else   pht[pidx(res_pc)] = (pht[pidx(res_pc)] == 0) ? 0 : pht[pidx(res_pc)] - 1;
         n_br++;
         if (exp_mp) n_mp++;
      end
      check_regs(exp_bt, exp_mp);
   endtask

   task automatic idle(input logic [31:0] lpc);
      drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, lpc);
      step();
   endtask

   initial begin
      model_reset();
      #12;
      chk("reset_branch_taken", branch_taken, 1'b0);
      check_regs(1'b0, 1'b0);
      for (int i = 0; i < 64; i++) begin
         lookup_pc = 32'(i * 4);
         #1;
         chk("reset_sweep_predict", predict_taken, 1'b0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // BEQ taken, predicted not taken
      drive(1'b1, 32'h40, 3'd1, 1'b0, 32'h1234, 32'h1234, 1'b0, 32'h0);
      step();
      chk("beq_mispredict", mispredict, 1'b1);
      idle(32'h40);
      chk("beq_pulse_one_cycle", mispredict, 1'b0);
      #1;
      chk("beq_predict_after", predict_taken, 1'b1);

      // four taken BGTZ then one not taken at one PC
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h80, 3'd4, 1'b1, 32'd5, 32'd0, 1'b0, 32'h80);
         step();
      end
      drive(1'b1, 32'h80, 3'd4, 1'b1, 32'd0, 32'd0, 1'b0, 32'h80);
      step();
      idle(32'h80);
      #1;
      chk("bgtz_predict_after_nt", predict_taken, 1'b1);

      // signed edge cases
      drive(1'b1, 32'h100, 3'd5, 1'b0, 32'h80000000, 32'h0, 1'b0, 32'h0); step();
      chk("bltz_min_taken", branch_taken, 1'b1);
      drive(1'b1, 32'h100, 3'd3, 1'b0, 32'h80000000, 32'h0, 1'b0, 32'h0); step();
      chk("blez_min_taken", branch_taken, 1'b1);
      drive(1'b1, 32'h100, 3'd6, 1'b0, 32'h80000000, 32'h0, 1'b0, 32'h0); step();
      chk("bgez_min_nt", branch_taken, 1'b0);
      drive(1'b1, 32'h104, 3'd3, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); step();
      chk("blez_zero_taken", branch_taken, 1'b1);
      drive(1'b1, 32'h104, 3'd4, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); step();
      chk("bgtz_zero_nt", branch_taken, 1'b0);
      drive(1'b1, 32'h104, 3'd6, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); step();
      chk("bgez_zero_taken", branch_taken, 1'b1);

      // stalled and invalid-type resolves are ignored
      drive(1'b1, 32'h200, 3'd1, 1'b0, 32'h7, 32'h7, 1'b1, 32'h200); step();
      chk("stall_no_mispredict", mispredict, 1'b0);
      drive(1'b1, 32'h200, 3'd7, 1'b1, 32'h7, 32'h7, 1'b0, 32'h200); step();
      chk("type7_no_mispredict", mispredict, 1'b0);
      drive(1'b1, 32'h200, 3'd0, 1'b1, 32'h7, 32'h7, 1'b0, 32'h200); step();
      idle(32'h200);

      // same-index collision: aliased PC, old value first then new
      drive(1'b1, 32'h300, 3'd1, 1'b0, 32'h1, 32'h1, 1'b0, 32'hF000_0302);
      step();
      #1;
      chk("collision_new_value", predict_taken, 1'b1);

      // mispredicted branches to saturate the 4-bit statistics
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 32'(k * 4), 3'd2, 1'b0, 32'h1, 32'h2, 1'b0, 32'(k * 8));
         step();
      end
      chk("w4_branches_saturated", stat_br4, 4'hF);
      chk("w4_mispredicts_saturated", stat_mp4, 4'hF);

      // reset in the middle of a mispredict pulse
      drive(1'b1, 32'h10, 3'd1, 1'b1, 32'h1, 32'h2, 1'b0, 32'h10);
      step();
      chk("pre_reset_pulse", mispredict, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("reset_drops_mispredict", mispredict, 1'b0);
      check_regs(1'b0, 1'b0);
      chk("reset_predict_init", predict_taken, 1'b0);
      #2;
      rst_n = 1'b1;
      drive(1'b0, 32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      @(posedge clk); #1;

      // randomized traffic, small PC pool so entries get revisited
      for (int n = 0; n < 600; n++) begin
         logic [31:0] pc, lpc, rs, rt;
         pc  = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'h0, 8'($urandom_range(0, 31) * 4)} | 32'($urandom_range(0, 3));
         lpc = ($urandom_range(0, 3) == 0) ? pc : {$urandom, 2'b00} >> 2;
         case ($urandom_range(0, 3))
            0: rs = 32'h0;
            1: rs = 32'h80000000;
            default: rs = $urandom;
         endcase
         rt = ($urandom_range(0, 2) == 0) ? rs : $urandom;
         drive($urandom_range(0, 4) != 0, pc, 3'($urandom_range(0, 7)),
               1'($urandom), rs, rt, $urandom_range(0, 5) == 0, lpc);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout: simulation exceeded time budget");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
